// File: rtl/sound_sequencer_if.sv
// Sound request/status bundle between the game logic and the tone sequencer.
//
// Handshake: req is a fire-and-forget strobe with no ready. Each req bit is
// a one-cycle pulse that the sequencer latches into its pending set.
// ack is the one-cycle, one-hot acceptance pulse for the granted source.
// Status lines (grant, busy, done, dac_code) are registered level/pulse
// outputs and need no handshake.
interface sound_sequencer_if;
  logic [2:0] req;
  logic [2:0] ack;
  logic [2:0] grant;
  logic       busy;
  logic       done;
  logic [7:0] dac_code;

  modport master (output req, input ack, input grant, input busy, input done, input dac_code);
  modport slave  (input req, output ack, output grant, output busy, output done, output dac_code);
endinterface

// File: rtl/sound_sequencer.sv
// Three-source priority tone sequencer driving a sigma-delta DAC input.
// Source 0 (score) beats source 1 (paddle) beats source 2 (wall). A tone is
// a square wave about mid-scale; each completed or abandoned tone is either
// followed by a silent gap or replaced immediately by a higher-priority tone.
module sound_sequencer #(
  parameter int TICK_DIV  = 250,
  parameter int HALF_P0   = 40,
  parameter int HALF_P1   = 20,
  parameter int HALF_P2   = 30,
  parameter int DUR0      = 2000,
  parameter int DUR1      = 500,
  parameter int DUR2      = 300,
  parameter int GAP_TICKS = 50,
  parameter int AMP       = 96
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sound_sequencer_if.slave  bus,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  HP0       = 8'(HALF_P0);
  localparam logic [7:0]  HP1       = 8'(HALF_P1);
  localparam logic [7:0]  HP2       = 8'(HALF_P2);
  localparam logic [11:0] DL0       = 12'(DUR0);
  localparam logic [11:0] DL1       = 12'(DUR1);
  localparam logic [11:0] DL2       = 12'(DUR2);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_TICKS - 1);
  localparam logic [7:0]  DAC_MID   = 8'd128;
  localparam logic [7:0]  DAC_HI    = 8'(128 + AMP);
  localparam logic [7:0]  DAC_LO    = 8'(128 - AMP);

  state_t      r_state, w_state_n;
  logic [15:0] r_pre;
  logic [2:0]  r_pend, w_pend_n;
  logic [7:0]  r_half, w_half_n;
  logic [11:0] r_dur, w_dur_n;
  logic [7:0]  r_gap, w_gap_n;
  logic        r_phase, w_phase_n;
  logic [2:0]  r_ack, w_ack_n;
  logic [2:0]  r_grant, w_grant_n;
  logic        r_done, w_done_n;
  logic        r_busy, w_busy_n;
  logic [7:0]  r_dac, w_dac_n;

  logic        w_tick;
  logic [2:0]  w_req_eff;
  logic [2:0]  w_arb;
  logic [2:0]  w_win;
  logic [2:0]  w_higher;
  logic [7:0]  w_half_lim;
  logic [11:0] w_dur_lim;

  // Free-running prescaler; the tick is its terminal count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            r_pre <= 16'd0;
    else if (r_pre == TICK_LAST) r_pre <= 16'd0;
    else                     r_pre <= r_pre + 16'd1;
  end

  assign w_tick = (r_pre == TICK_LAST);

  // Arbitration: a repeat request from the source already playing is
  // dropped; everything else joins the pending set, lowest index wins.
  always_comb begin
    w_req_eff = bus.req & ((r_state == S_PLAY) ? ~r_grant : 3'b111);
    w_arb     = r_pend | w_req_eff;
    w_higher  = w_arb & (r_grant - 3'd1);
    w_win     = 3'b000;
    if (w_arb[0])      w_win = 3'b001;
    else if (w_arb[1]) w_win = 3'b010;
    else if (w_arb[2]) w_win = 3'b100;
  end

  // Per-source tone shape selected by the current grant.
  always_comb begin
    w_half_lim = HP0;
    w_dur_lim  = DL0;
    case (r_grant)
      3'b010:  begin w_half_lim = HP1; w_dur_lim = DL1; end
      3'b100:  begin w_half_lim = HP2; w_dur_lim = DL2; end
      default: begin w_half_lim = HP0; w_dur_lim = DL0; end
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend | w_req_eff;
    w_half_n  = r_half;
    w_dur_n   = r_dur;
    w_gap_n   = r_gap;
    w_phase_n = r_phase;
    w_grant_n = r_grant;
    w_ack_n   = 3'b000;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb != 3'b000) begin
          w_state_n = S_PLAY;
          w_grant_n = w_win;
          w_ack_n   = w_win;
          w_pend_n  = w_pend_n & ~w_win;
          w_half_n  = 8'd0;
          w_dur_n   = 12'd0;
          w_phase_n = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_higher != 3'b000) begin
          // Preemption abandons the current tone without a done pulse.
          w_grant_n = w_win;
          w_ack_n   = w_win;
          w_pend_n  = w_pend_n & ~w_win;
          w_half_n  = 8'd0;
          w_dur_n   = 12'd0;
          w_phase_n = 1'b1;
        end else if (w_tick) begin
          if (r_dur == w_dur_lim - 12'd1) begin
            w_state_n = S_GAP;
            w_done_n  = 1'b1;
            w_grant_n = 3'b000;
            w_gap_n   = 8'd0;
          end else begin
            w_dur_n = r_dur + 12'd1;
          end
          if (r_half == w_half_lim - 8'd1) begin
            w_half_n  = 8'd0;
            w_phase_n = ~r_phase;
          end else begin
            w_half_n = r_half + 8'd1;
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_gap == GAP_LAST) w_state_n = S_IDLE;
          else                   w_gap_n   = r_gap + 8'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
    if (w_state_n == S_PLAY) w_dac_n = w_phase_n ? DAC_HI : DAC_LO;
    else                     w_dac_n = DAC_MID;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= 3'b000;
      r_half  <= 8'd0;
      r_dur   <= 12'd0;
      r_gap   <= 8'd0;
      r_phase <= 1'b0;
      r_ack   <= 3'b000;
      r_grant <= 3'b000;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_dac   <= DAC_MID;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_half  <= w_half_n;
      r_dur   <= w_dur_n;
      r_gap   <= w_gap_n;
      r_phase <= w_phase_n;
      r_ack   <= w_ack_n;
      r_grant <= w_grant_n;
      r_done  <= w_done_n;
      r_busy  <= w_busy_n;
      r_dac   <= w_dac_n;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.dac_code = r_dac;
  assign o_state      = r_state;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer with TICK_DIV=4, HALF_P=2/3/4, DUR=8/6/4,
// GAP_TICKS=2, AMP=100. Expected per-cycle output words come from tone
// timing worked out from the prescaler phase at PLAY entry.
module tb_sound_sequencer;
  localparam int TD = 4;
  localparam logic [15:0] IDLE_W = {3'b000, 3'b000, 1'b0, 1'b0, 8'd128};

  typedef struct packed {
    logic [2:0] req;
    logic [1:0] n_tones;
    logic [5:0] order;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int cyc;
  int n_vec = 0;
  int n_err = 0;
  int half_t[3] = '{2, 3, 4};
  int dur_t[3]  = '{8, 6, 4};
  logic [15:0] exp_q[$];
  vec_t vecs[6];

  sound_sequencer_if bus();

  sound_sequencer #(
    .TICK_DIV(4), .HALF_P0(2), .HALF_P1(3), .HALF_P2(4),
    .DUR0(8), .DUR1(6), .DUR2(4), .GAP_TICKS(2), .AMP(100)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus),
    .o_state(dbg_state)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] mk(logic [2:0] a, logic [2:0] g, logic b, logic d, logic [7:0] dac);
    return {a, g, b, d, dac};
  endfunction

  // Expected outputs after each edge, starting with the PLAY-entry edge.
  // p is the prescaler count right after that entry edge.
  function automatic void push_tones(int p, logic [5:0] order, int n);
    int pp;
    pp = p;
    for (int t = 0; t < n; t++) begin
      int src;
      logic [2:0] oh;
      int h, d, d1, m_done, m_idle, nt;
      src    = int'(order[2*t +: 2]);
      oh     = 3'b001 << src;
      h      = half_t[src];
      d      = dur_t[src];
      d1     = ((TD - 1 - pp) % TD) + 1;
      m_done = d1 + TD * (d - 1);
      m_idle = d1 + TD * (d + 1);
      exp_q.push_back(mk(oh, oh, 1'b1, 1'b0, 8'd228));
      for (int m = 1; m <= m_idle; m++) begin
        nt = (m >= d1) ? (m - d1) / TD + 1 : 0;
        if (m < m_done)
          exp_q.push_back(mk(3'b000, oh, 1'b1, 1'b0, ((nt / h) % 2 == 0) ? 8'd228 : 8'd28));
        else if (m == m_done)
          exp_q.push_back(mk(3'b000, 3'b000, 1'b1, 1'b1, 8'd128));
        else if (m < m_idle)
          exp_q.push_back(mk(3'b000, 3'b000, 1'b1, 1'b0, 8'd128));
        else
          exp_q.push_back(IDLE_W);
      end
      pp = (pp + m_idle + 1) % TD;
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(IDLE_W);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got ack=%b grant=%b busy=%b done=%b dac=%0d want ack=%b grant=%b busy=%b done=%b dac=%0d",
               name, cyc, got[15:13], got[12:10], got[9], got[8], got[7:0],
               exp[15:13], exp[12:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // driver: present a request pulse for the next edge; returns entry phase
  task automatic drive(input logic [2:0] r, output int p);
    bus.req = r;
    p = (cyc + 1) % TD;
  endtask

  // scoreboard: pop one expectation per edge and compare
  task automatic run_cycles(input int n, input string name);
    logic [15:0] got;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
      bus.req = 3'b000;
      got = {bus.ack, bus.grant, bus.busy, bus.done, bus.dac_code};
      check(name, got, exp_q.pop_front());
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) exp_q.push_back(IDLE_W);
    run_cycles(n, name);
  endtask

  initial begin
    int p;
    int guard;
    vecs[0] = '{3'b001, 2'd1, 6'b00_00_00};
    vecs[1] = '{3'b010, 2'd1, 6'b00_00_01};
    vecs[2] = '{3'b100, 2'd1, 6'b00_00_10};
    vecs[3] = '{3'b110, 2'd2, 6'b00_10_01};
    vecs[4] = '{3'b111, 2'd3, 6'b10_01_00};
    vecs[5] = '{3'b011, 2'd2, 6'b00_01_00};

    // reset with requests active: they must be ignored
    bus.req = 3'b111;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.ack, bus.grant, bus.busy, bus.done, bus.dac_code}, IDLE_W);
    check("reset_state", {14'd0, dbg_state}, 16'd0);
    bus.req = 3'b000;
    rst_n = 1'b1;
    idle_cycles(5, "post_reset_idle");

    // table-driven single and simultaneous requests
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        guard = 0;
        while (((cyc + 1) % TD) != 0 && guard < TD) begin
          idle_cycles(1, "align_idle");
          guard++;
        end
      end else begin
        idle_cycles($urandom_range(0, 3), "pre_idle");
      end
      drive(vecs[i].req, p);
      push_tones(p, vecs[i].order, int'(vecs[i].n_tones));
      run_cycles(exp_q.size(), $sformatf("vec%0d", i));
    end

    // preemption of source 2 by source 0
    drive(3'b100, p);
    push_tones(p, 6'b00_00_10, 1);
    run_cycles(7, "preempt_before");
    exp_q.delete();
    drive(3'b001, p);
    push_tones(p, 6'b00_00_00, 1);
    run_cycles(exp_q.size(), "preempt_after");

    // repeat request for the playing source is dropped
    drive(3'b010, p);
    push_tones(p, 6'b00_00_01, 1);
    run_cycles(6, "same_src_before");
    bus.req = 3'b010;
    run_cycles(exp_q.size(), "same_src_after");

    // lower-priority request during PLAY stays pending
    drive(3'b010, p);
    push_tones(p, 6'b00_10_01, 2);
    run_cycles(6, "low_pend_before");
    bus.req = 3'b100;
    run_cycles(exp_q.size(), "low_pend_after");

    // higher-priority request during GAP waits for the gap to finish
    drive(3'b010, p);
    push_tones(p, 6'b00_00_01, 2);
    run_cycles(26, "gap_hold_before");
    bus.req = 3'b001;
    run_cycles(exp_q.size(), "gap_hold_after");

    // reset mid-PLAY: abort, no done, request during reset ignored
    drive(3'b001, p);
    push_tones(p, 6'b00_00_00, 1);
    run_cycles(10, "rst_mid_before");
    exp_q.delete();
    rst_n = 1'b0;
    bus.req = 3'b010;
    @(posedge clk);
    #1;
    check("rst_mid_outputs", {bus.ack, bus.grant, bus.busy, bus.done, bus.dac_code}, IDLE_W);
    check("rst_mid_state", {14'd0, dbg_state}, 16'd0);
    rst_n = 1'b1;
    bus.req = 3'b000;
    idle_cycles(20, "rst_mid_silent");

    // tone after reset: tick phase restarts from the release
    drive(3'b100, p);
    push_tones(p, 6'b00_00_10, 1);
    run_cycles(exp_q.size(), "post_rst_tone");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 250: CLK cycles per sound tick; range 2..65535.
REQ-002 Parameters HALF_P0/HALF_P1/HALF_P2, defaults 40/20/30: tone half-period in ticks for sources 0/1/2 (score/paddle/wall); range 1..255.
REQ-003 Parameters DUR0/DUR1/DUR2, defaults 2000/500/300: tone duration in ticks per source; range 1..4095.
REQ-004 Parameter GAP_TICKS, default 50: silent ticks after each tone; range 1..255.
REQ-005 Parameter AMP, default 96: square-wave amplitude about mid-scale; range 0..127.
REQ-006 CLK  input  1  system clock; all state changes on rising edge.
REQ-007 Reset  input  1  synchronous, active-low reset.
REQ-008 req  input  3  single-cycle sound request pulses; bit 0 highest priority.
REQ-009 ack  output  3  one-hot, one-cycle pulse when the matching request is granted.
REQ-010 grant  output  3  one-hot source currently playing; 0 when not in PLAY.
REQ-011 busy  output  1  high in PLAY or GAP.
REQ-012 done  output  1  one-cycle pulse when a tone completes its full duration.
REQ-013 dac_code  output  8  unsigned sample driven to the sigma-delta DAC input.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 free-running; tick is high for the one cycle the count equals TICK_DIV-1.
REQ-015 Each source has a pending flag; set on any cycle req[i]=1, cleared on the cycle source i is granted.
REQ-016 Arbitration set = pending | req (same-cycle request is visible); winner = lowest index set.
REQ-017 States: IDLE, PLAY, GAP; all outputs registered.
REQ-018 IDLE: if arbitration set non-zero -> PLAY next edge with grant=winner, ack=winner pulse; else stay.
REQ-019 Request-to-ack latency 1 cycle from an IDLE state; dac_code leaves mid-scale on the same edge.
REQ-020 PLAY entry: phase=1, half-period counter=0, duration counter=0.
REQ-021 PLAY: on each tick, half counter increments; at HALF_Pn-1 it wraps to 0 and phase toggles.
REQ-022 PLAY: on each tick, duration counter increments; on the tick where it equals DURn-1 -> GAP, done pulse, grant=0.
REQ-023 Preemption: in PLAY, if a strictly higher-priority source is in the arbitration set, next edge restarts PLAY for it (counters per REQ-020, ack pulse, no done, old tone abandoned).
REQ-024 req for the source currently in PLAY is dropped (pending not set); lower-priority requests stay pending.
REQ-025 GAP: counts GAP_TICKS ticks, then -> IDLE; requests arriving in GAP are held pending, no preemption of GAP.
REQ-026 dac_code = 128+AMP when PLAY and phase=1; 128-AMP when PLAY and phase=0; 128 otherwise.
REQ-027 Simultaneous req bits: only the winner is acked; others remain pending and are served in priority order after each GAP.
REQ-028 Counters sized to parameter maxima; no overflow or wrap other than specified.

Reset
REQ-029 Reset low at an edge: state=IDLE, prescaler=0, all counters=0, pending=0, phase=0, ack=0, grant=0, busy=0, done=0, dac_code=128.
REQ-030 Reset low mid-tone aborts it with no done pulse; req during reset is ignored.
REQ-031 First tick after reset release occurs TICK_DIV cycles after the first non-reset edge.

Verification (TICK_DIV=4, HALF_P=2/3/4, DUR=8/6/4, GAP_TICKS=2, AMP=100)
REQ-032 req=001 pulse in IDLE -> next cycle ack=001, grant=001, dac_code=228; toggles to 28 every 8 cycles; done after 32 cycles; busy low 8 cycles later, dac_code=128.
REQ-033 req=110 same cycle -> ack=010 only; source 2 plays after source 1 GAP completes, ack=100 on its PLAY entry.
REQ-034 Source 2 playing, req=001 -> next edge grant=001, ack=001, no done, dac_code=228, duration restarts from 0.
REQ-035 Source 1 playing, req=010 again -> ignored; no second tone after GAP, busy falls after GAP.
REQ-036 Reset low mid-PLAY for one edge -> all outputs at REQ-029 values, pending cleared, no done pulse, no tone after release.
